// File: rtl/pic_latch_pkg.sv
// Shared types and defaults for the latch bank driver.
//   drv_state_e : bus drive state machine encoding
//   DefWidth    : default entry/bus width
//   DefDepth    : default number of entries
package pic_latch_pkg;

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_TURN} drv_state_e;

    localparam int unsigned DefWidth = 24;
    localparam int unsigned DefDepth = 4;

endpackage

// File: rtl/latch_bank_store.sv
// DEPTH x WIDTH holding register array with per-entry valid bits.
//   clk_i, rst_n_i         : clock, async active-low reset
//   wr_en_i/addr/data      : write port, out-of-range addresses ignored
//   clr_i                  : clear all valid bits, data retained
//   rd_addr_i              : combinational read address
//   rd_data_o, rd_valid_o  : stored data (0 if out of range) and its valid bit
//   valid_o                : per-entry valid bits
module latch_bank_store
    import pic_latch_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned DEPTH = DefDepth
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     clr_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     rd_valid_o,
    output logic [DEPTH-1:0]         valid_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DepthW = DEPTH[AW:0];

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic             wr_in_range, rd_in_range;

    assign wr_in_range = {1'b0, wr_addr_i} < DepthW;
    assign rd_in_range = {1'b0, rd_addr_i} < DepthW;

    always_comb begin
        data_d  = data_q;
        valid_d = clr_i ? '0 : valid_q;
        // Applied after the clear so a same-cycle write keeps its own valid bit.
        if (wr_en_i && wr_in_range) begin
            data_d[wr_addr_i]  = wr_data_i;
            valid_d[wr_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    // Reads see the registered contents, so a same-cycle write is not bypassed.
    assign rd_data_o  = rd_in_range ? data_q[rd_addr_i] : '0;
    assign rd_valid_o = rd_in_range && valid_q[rd_addr_i];
    assign valid_o    = valid_q;

endmodule

// File: rtl/latch_bank_drv.sv
// Bank of holding registers driving one shared (optionally tri-state) bus.
//   clk_i, rst_n_i      : clock, async active-low reset
//   wr_en_i/addr/data   : write an entry and mark it valid
//   clr_i               : clear all valid bits
//   rd_req_i, rd_addr_i : request to drive an entry; accepted when rd_rdy_o
//   rd_rdy_o            : low only in the turnaround cycle
//   out_q               : bus output, driven from the capture register only
//   drv_o               : bus actively driven
//   rd_err_o            : one-cycle pulse, accepted read hit an invalid entry
//   valid_o             : per-entry valid bits
module latch_bank_drv
    import pic_latch_pkg::*;
#(
    parameter int unsigned WIDTH    = DefWidth,
    parameter int unsigned DEPTH    = DefDepth,
    parameter bit          TRISTATE = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     clr_i,
    input  logic                     rd_req_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic                     rd_rdy_o,
    output logic [WIDTH-1:0]         out_q,
    output logic                     drv_o,
    output logic                     rd_err_o,
    output logic [DEPTH-1:0]         valid_o
);

    drv_state_e       state_q, state_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             accept;

    latch_bank_store #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_store (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .wr_en_i   (wr_en_i),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .clr_i     (clr_i),
        .rd_addr_i (rd_addr_i),
        .rd_data_o (rd_data),
        .rd_valid_o(rd_valid),
        .valid_o   (valid_o)
    );

    assign rd_rdy_o = (state_q != S_TURN);
    assign accept   = rd_req_i && rd_rdy_o;

    always_comb begin
        state_d = state_q;
        cap_d   = accept ? rd_data : cap_q;
        err_d   = accept && !rd_valid;
        unique case (state_q)
            S_IDLE:  if (accept) state_d = S_DRIVE;
            S_DRIVE: state_d = accept ? S_DRIVE : S_TURN;
            S_TURN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cap_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            err_q   <= err_d;
        end
    end

    assign drv_o    = (state_q == S_DRIVE);
    assign rd_err_o = err_q;

    // Bus depends on registers only; reset releases it asynchronously via state_q.
    if (TRISTATE) begin : g_tri
        assign out_q = drv_o ? cap_q : {WIDTH{1'bz}};
    end else begin : g_zero
        assign out_q = drv_o ? cap_q : '0;
    end

endmodule

// File: tb/tb_latch_bank_drv.sv
module tb_latch_bank_drv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [23:0] wr_data;
    logic        clr;
    logic        rd_req;
    logic [1:0]  rd_addr;

    logic        rdy, drv, err;
    logic [3:0]  valid;
    wire  [23:0] bus_z;
    logic [23:0] bus_0;
    logic        rdy0, drv0, err0;
    logic [3:0]  valid0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    latch_bank_drv #(.WIDTH(24), .DEPTH(4), .TRISTATE(1'b1)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .clr_i(clr), .rd_req_i(rd_req), .rd_addr_i(rd_addr),
        .rd_rdy_o(rdy), .out_q(bus_z), .drv_o(drv), .rd_err_o(err), .valid_o(valid)
    );

    // Zero-when-idle variant makes the released bus value observable.
    latch_bank_drv #(.WIDTH(24), .DEPTH(4), .TRISTATE(1'b0)) u_dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .clr_i(clr), .rd_req_i(rd_req), .rd_addr_i(rd_addr),
        .rd_rdy_o(rdy0), .out_q(bus_0), .drv_o(drv0), .rd_err_o(err0), .valid_o(valid0)
    );

    typedef struct {
        logic        wr_en;
        logic [1:0]  wr_addr;
        logic [23:0] wr_data;
        logic        clr;
        logic        rd_req;
        logic [1:0]  rd_addr;
        logic        e_drv;
        logic        e_rdy;
        logic        e_err;
        logic [3:0]  e_valid;
        logic [23:0] e_out;
    } vec_t;

    localparam int NVec = 21;
    vec_t vec [NVec];

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (vec %0d): got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_addr = 2'd0; wr_data = 24'h0;
        clr = 1'b0; rd_req = 1'b0; rd_addr = 2'd0;
    endtask

    task automatic check_outputs(input int idx, input logic e_drv, input logic e_rdy,
                                 input logic e_err, input logic [3:0] e_valid,
                                 input logic [23:0] e_out);
        check("drv_o", idx, {31'd0, drv}, {31'd0, e_drv});
        check("rd_rdy_o", idx, {31'd0, rdy}, {31'd0, e_rdy});
        check("rd_err_o", idx, {31'd0, err}, {31'd0, e_err});
        check("valid_o", idx, {28'd0, valid}, {28'd0, e_valid});
        check("out_q_zero", idx, {8'd0, bus_0}, {8'd0, e_drv ? e_out : 24'h0});
        if (e_drv) check("out_q_tri", idx, {8'd0, bus_z}, {8'd0, e_out});
    endtask

    initial begin
        //            wr  wa    wdata        clr   rq    ra    drv   rdy   err   valid    out
        vec[0]  = '{1'b1, 2'd2, 24'hA5A5A5, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'b0100, 24'h0};
        vec[1]  = '{1'b0, 2'd0, 24'h0,      1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 4'b0100, 24'hA5A5A5};
        vec[2]  = '{1'b0, 2'd0, 24'h0,      1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'b0100, 24'h0};
        vec[3]  = '{1'b0, 2'd0, 24'h0,      1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'b0100, 24'h0};
        vec[4]  = '{1'b1, 2'd0, 24'h123456, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'b0101, 24'h0};
        vec[5]  = '{1'b1, 2'd1, 24'hABCDEF, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'b0111, 24'h0};
        vec[6]  = '{1'b1, 2'd3, 24'h000042, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'b1111, 24'h0};
        vec[7]  = '{1'b0, 2'd0, 24'h0,      1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 4'b1111, 24'h123456};
        vec[8]  = '{1'b0, 2'd0, 24'h0,      1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 4'b1111, 24'hABCDEF};
        vec[9]  = '{1'b0, 2'd0, 24'h0,      1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'b1111, 24'h0};
        // Request held through TURN: not accepted there, state returns to IDLE.
        vec[10] = '{1'b0, 2'd0, 24'h0,      1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 4'b1111, 24'h0};
        // Same-cycle write and read of entry 3: old contents captured.
        vec[11] = '{1'b1, 2'd3, 24'h111111, 1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0, 4'b1111, 24'h000042};
        vec[12] = '{1'b0, 2'd0, 24'h0,      1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0, 4'b1111, 24'h111111};
        vec[13] = '{1'b0, 2'd0, 24'h0,      1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'b1111, 24'h0};
        vec[14] = '{1'b0, 2'd0, 24'h0,      1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'b1111, 24'h0};
        vec[15] = '{1'b0, 2'd0, 24'h0,      1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'b0000, 24'h0};
        vec[16] = '{1'b0, 2'd0, 24'h0,      1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 4'b0000, 24'hABCDEF};
        vec[17] = '{1'b0, 2'd0, 24'h0,      1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 24'h0};
        vec[18] = '{1'b0, 2'd0, 24'h0,      1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'b0000, 24'h0};
        vec[19] = '{1'b1, 2'd0, 24'h777777, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'b0001, 24'h0};
        vec[20] = '{1'b0, 2'd0, 24'h0,      1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 4'b0001, 24'h777777};

        idle_inputs();
        rst_n = 1'b0;
        #12;
        check_outputs(-1, 1'b0, 1'b1, 1'b0, 4'b0000, 24'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs(-2, 1'b0, 1'b1, 1'b0, 4'b0000, 24'h0);

        for (int i = 0; i < NVec; i++) begin
            wr_en   = vec[i].wr_en;
            wr_addr = vec[i].wr_addr;
            wr_data = vec[i].wr_data;
            clr     = vec[i].clr;
            rd_req  = vec[i].rd_req;
            rd_addr = vec[i].rd_addr;
            @(posedge clk);
            #1;
            check_outputs(i, vec[i].e_drv, vec[i].e_rdy, vec[i].e_err, vec[i].e_valid,
                          vec[i].e_out);
        end

        // Reset asserted while driving entry 0: bus released without waiting for an edge.
        idle_inputs();
        rd_req = 1'b1;
        @(posedge clk);
        #1;
        check_outputs(100, 1'b1, 1'b1, 1'b0, 4'b0001, 24'h777777);
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs(101, 1'b0, 1'b1, 1'b0, 4'b0000, 24'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs(102, 1'b0, 1'b1, 1'b0, 4'b0000, 24'h0);

        // Stored data also cleared by reset: reading entry 0 drives zero and flags invalid.
        rd_req = 1'b1;
        rd_addr = 2'd0;
        @(posedge clk);
        #1;
        check_outputs(103, 1'b1, 1'b1, 1'b1, 4'b0000, 24'h0);
        idle_inputs();
        @(posedge clk);
        #1;
        check_outputs(104, 1'b0, 1'b0, 1'b0, 4'b0000, 24'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
